mem_wb_unit: RTL and testbench

- Memory-access and write-back back end of the 5-stage pipeline.
- Accepts EX/MEM-stage control and data, performs data-memory load/store, and holds the MEM/WB pipeline register.
- Produces the register-file write port (reg_2_write_87 / data_2_write_87 / en_wb_87) consumed by instr_decode_unit.
- Exports EX/MEM and MEM/WB forwarding sources for the forwarding unit.

---
 rtl/mem_wb_unit.sv | 157 +++++++++++++++
 tb/tb_mem_wb_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_unit.sv
// mem_wb_unit: memory-access and write-back back end of the 5-stage pipeline.
// Performs data-memory loads/stores (word addressed, synchronous read),
// holds the MEM/WB pipeline register, drives the register-file write port,
// and exports EX/MEM and MEM/WB forwarding sources.
// Optional feature macro: MEM_WB_RETIRE_CNT_EN adds a saturating retire
// counter output (retire_cnt_87).
module mem_wb_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_87,
    input  logic                      rst_87,
    input  logic                      valid_87,
    input  logic                      reg_write_87,
    input  logic                      mem_to_reg_87,
    input  logic                      mem_read_87,
    input  logic                      mem_write_87,
    input  logic [DATA_WIDTH-1:0]     alu_result_87,
    input  logic [DATA_WIDTH-1:0]     store_data_87,
    input  logic [REG_ADDR_WIDTH-1:0] wreg_87,
    output logic [REG_ADDR_WIDTH-1:0] reg_2_write_87,
    output logic [DATA_WIDTH-1:0]     data_2_write_87,
    output logic                      en_wb_87,
    output logic [REG_ADDR_WIDTH-1:0] fwd_mem_reg_87,
    output logic                      fwd_mem_en_87,
    output logic [DATA_WIDTH-1:0]     fwd_mem_data_87,
    output logic                      misalign_87
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]               retire_cnt_87
`endif
);

    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int IDX_LSB   = 2;
    localparam int IDX_MSB   = MEM_DEPTH_LOG2 + 1;

    // ------------------------------------------------------------------
    // Address decode and access qualification
    // ------------------------------------------------------------------
    logic [MEM_DEPTH_LOG2-1:0] word_idx;
    logic                      mem_access;
    logic                      addr_misaligned;
    logic                      access_misaligned;
    logic                      store_en;
    logic                      load_en;

    // Upper address bits are dropped, so byte addresses wrap modulo the memory size.
    assign word_idx          = alu_result_87[IDX_MSB:IDX_LSB];
    assign mem_access        = valid_87 && (mem_read_87 || mem_write_87);
    assign addr_misaligned   = |alu_result_87[1:0];
    assign access_misaligned = mem_access && addr_misaligned;

    // A store wins over a read request; reset suppresses any store in flight.
    assign store_en = !rst_87 && valid_87 && mem_write_87 && !addr_misaligned;
    assign load_en  = valid_87 && mem_read_87 && !mem_write_87 && !addr_misaligned;

    // ------------------------------------------------------------------
    // Data memory: plain array with registered read so it maps to block RAM.
    // Contents are deliberately not cleared by reset.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Write port: commit an aligned store at the edge.
    always_ff @(posedge clk_87) begin
        if (store_en) begin
            mem[word_idx] <= store_data_87;
        end
    end

    // Read port: synchronous read, only enabled for an aligned load.
    always_ff @(posedge clk_87) begin
        if (load_en) begin
            rd_data_reg <= mem[word_idx];
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    logic                      wb_valid_reg;
    logic                      wb_reg_write_reg;
    logic                      wb_mem_to_reg_reg;
    logic                      wb_load_ok_reg;
    logic [DATA_WIDTH-1:0]     wb_alu_reg;
    logic [REG_ADDR_WIDTH-1:0] wb_wreg_reg;
    logic                      misalign_reg;
    logic                      misalign_next;
    logic [DATA_WIDTH-1:0]     wb_load_data;

    // The misaligned flag is sticky: once set it only clears on reset.
    assign misalign_next = misalign_reg | access_misaligned;

    // Capture the EX/MEM slot every cycle; there is no stall path.
    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            wb_valid_reg      <= 1'b0;
            wb_reg_write_reg  <= 1'b0;
            wb_mem_to_reg_reg <= 1'b0;
            wb_load_ok_reg    <= 1'b0;
            wb_alu_reg        <= '0;
            wb_wreg_reg       <= '0;
            misalign_reg      <= 1'b0;
        end else begin
            wb_valid_reg      <= valid_87;
            wb_reg_write_reg  <= reg_write_87;
            wb_mem_to_reg_reg <= mem_to_reg_87;
            wb_load_ok_reg    <= load_en;
            wb_alu_reg        <= alu_result_87;
            wb_wreg_reg       <= wreg_87;
            misalign_reg      <= misalign_next;
        end
    end

    // The RAM read register has no reset, so a qualifier register forces
    // load data to zero for suppressed (misaligned) or absent loads.
    assign wb_load_data = wb_load_ok_reg ? rd_data_reg : '0;

    // ------------------------------------------------------------------
    // Write-back port (also serves as the MEM/WB forwarding source)
    // ------------------------------------------------------------------
    assign data_2_write_87 = wb_mem_to_reg_reg ? wb_load_data : wb_alu_reg;
    assign reg_2_write_87  = wb_wreg_reg;
    assign en_wb_87        = wb_valid_reg && wb_reg_write_reg && (wb_wreg_reg != '0);
    assign misalign_87     = misalign_reg;

    // ------------------------------------------------------------------
    // EX/MEM forwarding: ALU results only; load results are not yet known.
    // ------------------------------------------------------------------
    assign fwd_mem_reg_87  = wreg_87;
    assign fwd_mem_data_87 = alu_result_87;
    assign fwd_mem_en_87   = valid_87 && reg_write_87 && !mem_to_reg_87 && (wreg_87 != '0);

`ifdef MEM_WB_RETIRE_CNT_EN
    // ------------------------------------------------------------------
    // Retire counter: one count per edge that retires a write-back or a store.
    // ------------------------------------------------------------------
    logic [31:0] retire_cnt_reg;
    logic        retire_event;

    assign retire_event = en_wb_87 || store_en;

    // Saturating counter, cleared by reset.
    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            retire_cnt_reg <= '0;
        end else if (retire_event && (retire_cnt_reg != 32'hFFFF_FFFF)) begin
            retire_cnt_reg <= retire_cnt_reg + 32'd1;
        end
    end

    assign retire_cnt_87 = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_wb_unit.sv
// tb_mem_wb_unit: scoreboard bench for mem_wb_unit. A driver issues one
// instruction per cycle at the falling edge and pushes the expected
// write-back response from a behavioural model; a monitor pops and compares
// one response after every rising edge.
module tb_mem_wb_unit;

    logic        clk_87;
    logic        rst_87;
    logic        valid_87;
    logic        reg_write_87;
    logic        mem_to_reg_87;
    logic        mem_read_87;
    logic        mem_write_87;
    logic [31:0] alu_result_87;
    logic [31:0] store_data_87;
    logic [4:0]  wreg_87;
    logic [4:0]  reg_2_write_87;
    logic [31:0] data_2_write_87;
    logic        en_wb_87;
    logic [4:0]  fwd_mem_reg_87;
    logic        fwd_mem_en_87;
    logic [31:0] fwd_mem_data_87;
    logic        misalign_87;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_87;
`endif

    mem_wb_unit #(
        .DATA_WIDTH     (32),
        .MEM_DEPTH_LOG2 (8),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk_87          (clk_87),
        .rst_87          (rst_87),
        .valid_87        (valid_87),
        .reg_write_87    (reg_write_87),
        .mem_to_reg_87   (mem_to_reg_87),
        .mem_read_87     (mem_read_87),
        .mem_write_87    (mem_write_87),
        .alu_result_87   (alu_result_87),
        .store_data_87   (store_data_87),
        .wreg_87         (wreg_87),
        .reg_2_write_87  (reg_2_write_87),
        .data_2_write_87 (data_2_write_87),
        .en_wb_87        (en_wb_87),
        .fwd_mem_reg_87  (fwd_mem_reg_87),
        .fwd_mem_en_87   (fwd_mem_en_87),
        .fwd_mem_data_87 (fwd_mem_data_87),
        .misalign_87     (misalign_87)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .retire_cnt_87   (retire_cnt_87)
`endif
    );

    initial clk_87 = 1'b0;
    always #5 clk_87 = ~clk_87;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        bit          data_known;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Behavioural model state: word memory, sticky flag, retire count.
    logic [31:0] m_mem   [256];
    bit          m_known [256];
    bit          m_mis;
    bit          m_prev_en;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one EX/MEM slot and record what the write-back port must show next.
    task automatic step(input bit r, input bit v, input bit rw, input bit m2r,
                        input bit mr, input bit mw, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] wr);
        exp_t e;
        bit   mis_acc;
        bit   ld;
        bit   st;
        int   idx;
        @(negedge clk_87);
        rst_87        = r;
        valid_87      = v;
        reg_write_87  = rw;
        mem_to_reg_87 = m2r;
        mem_read_87   = mr;
        mem_write_87  = mw;
        alu_result_87 = a;
        store_data_87 = sd;
        wreg_87       = wr;

        idx     = int'((a / 4) % 256);
        mis_acc = v && (mr || mw) && ((a % 4) != 0);
        ld      = v && mr && !mw;
        st      = v && mw && !mis_acc;
        if (r) begin
            m_mis        = 1'b0;
            m_cnt        = 32'd0;
            m_prev_en    = 1'b0;
            e.en         = 1'b0;
            e.rg         = 5'd0;
            e.data       = 32'd0;
            e.data_known = 1'b1;
            e.mis        = 1'b0;
            e.cnt        = 32'd0;
        end else begin
            if ((m_prev_en || st) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            e.en = v && rw && (wr != 0);
            e.rg = wr;
            if (!m2r) begin
                e.data = a; e.data_known = 1'b1;
            end else if (ld && mis_acc) begin
                e.data = 32'd0; e.data_known = 1'b1;
            end else if (ld) begin
                e.data = m_mem[idx]; e.data_known = m_known[idx];
            end else begin
                e.data = 32'd0; e.data_known = 1'b0;
            end
            if (st) begin
                m_mem[idx]   = sd;
                m_known[idx] = 1'b1;
            end
            m_mis     = m_mis || mis_acc;
            e.mis     = m_mis;
            e.cnt     = m_cnt;
            m_prev_en = e.en;
        end
        exp_q.push_back(e);

        // EX/MEM forwarding is combinational on the current slot.
        #1;
        check("fwd_en", {31'd0, fwd_mem_en_87}, {31'd0, (v && rw && !m2r && wr != 0)});
        check("fwd_reg", {27'd0, fwd_mem_reg_87}, {27'd0, wr});
        check("fwd_data", fwd_mem_data_87, a);
    endtask

    // Monitor: one write-back response per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_87);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: en=%0b reg=%0d data=%h mis=%0b", txn,
                         en_wb_87, reg_2_write_87, data_2_write_87, misalign_87);
                check("en_wb", {31'd0, en_wb_87}, {31'd0, e.en});
                check("reg_2_write", {27'd0, reg_2_write_87}, {27'd0, e.rg});
                if (e.data_known) check("data_2_write", data_2_write_87, e.data);
                check("misalign", {31'd0, misalign_87}, {31'd0, e.mis});
`ifdef MEM_WB_RETIRE_CNT_EN
                check("retire_cnt", retire_cnt_87, e.cnt);
`endif
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        int          kind;
        int          waited;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        m_mis = 1'b0; m_prev_en = 1'b0; m_cnt = 32'd0;
        rst_87 = 1'b1; valid_87 = 1'b0; reg_write_87 = 1'b0; mem_to_reg_87 = 1'b0;
        mem_read_87 = 1'b0; mem_write_87 = 1'b0; alu_result_87 = 32'd0;
        store_data_87 = 32'd0; wreg_87 = 5'd0;

        //     r  v  rw m2r mr mw addr          store data    wreg
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0,         5'd0);
        step(0, 1, 0, 0, 0, 1, 32'h10,        32'h1111_1111, 5'd0);
        // Reset for two cycles with a store presented: must not commit.
        step(1, 1, 0, 0, 0, 1, 32'h10,        32'hCAFE_BABE, 5'd0);
        step(1, 1, 0, 0, 0, 1, 32'h10,        32'hCAFE_BABE, 5'd0);
        step(0, 1, 1, 1, 1, 0, 32'h10,        32'h0,         5'd7);
        // ALU write-back and forwarding.
        step(0, 1, 1, 0, 0, 0, 32'h0000_1234, 32'h0,         5'd9);
        // Store then load back-to-back.
        step(0, 1, 0, 0, 0, 1, 32'h40,        32'hDEAD_BEEF, 5'd0);
        step(0, 1, 1, 1, 1, 0, 32'h40,        32'h0,         5'd3);
        // Write to $0, then a bubble.
        step(0, 1, 1, 0, 0, 0, 32'hABCD,      32'h0,         5'd0);
        step(0, 0, 1, 0, 0, 0, 32'h5678,      32'h0,         5'd5);
        // Address wrap.
        step(0, 1, 0, 0, 0, 1, 32'h400,       32'h55,        5'd0);
        step(0, 1, 1, 1, 1, 0, 32'h0,         32'h0,         5'd6);
        // Misaligned load, then the flag must stick.
        step(0, 1, 1, 1, 1, 0, 32'h41,        32'h0,         5'd4);
        step(0, 1, 1, 0, 0, 0, 32'h77,        32'h0,         5'd8);
        step(0, 1, 0, 0, 0, 1, 32'h42,        32'hBAD0_BAD0, 5'd0);
        step(0, 1, 1, 1, 1, 0, 32'h40,        32'h0,         5'd2);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0,         5'd0);

        for (int n = 0; n < 500; n++) begin
            kind = $urandom_range(0, 9);
            a = ($urandom() & 32'hFFFF_FC00) | ($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 39) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (kind <= 3) begin
                step($urandom_range(0, 59) == 0, 1, $urandom_range(0, 7) != 0, 0, 0, 0,
                     $urandom(), $urandom(), 5'($urandom_range(0, 31)));
            end else if (kind <= 5) begin
                step($urandom_range(0, 59) == 0, 1, 1, 1, 1, 0,
                     a, $urandom(), 5'($urandom_range(0, 31)));
            end else if (kind <= 8) begin
                step($urandom_range(0, 59) == 0, 1, 0, 0, 1'($urandom_range(0, 1)), 1,
                     a, $urandom(), 5'($urandom_range(0, 31)));
            end else begin
                step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     a, $urandom(), 5'($urandom_range(0, 31)));
            end
        end

        // Let the monitor drain the scoreboard, bounded.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk_87);
            #2;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
